// File: rtl/xilinx2asic_pkg.sv
// rtl/xilinx2asic_pkg.sv - shared helpers for the xilinx2asic primitive-replacement library
package xilinx2asic_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic bit depth_addr_ok(input int depth, input int addr_w);
        return (depth >= 2) && (depth <= 64) && ((1 << addr_w) >= depth);
    endfunction

endpackage

// File: rtl/ff_delay_line_if.sv
// rtl/ff_delay_line_if.sv - shift/tap bus of the addressable delay line
interface ff_delay_line_if #(
    parameter int WIDTH  = 1,
    parameter int ADDR_W = 4
);
    logic              CE;
    logic [WIDTH-1:0]  D;
    logic [ADDR_W-1:0] A;
    logic [WIDTH-1:0]  Q;
    logic [WIDTH-1:0]  QLAST;
    logic              Q_VALID;

    modport master (output CE, D, A, input Q, QLAST, Q_VALID);
    modport slave  (input CE, D, A, output Q, QLAST, Q_VALID);
endinterface

// File: rtl/ff_delay_tap_mux.sv
// rtl/ff_delay_tap_mux.sv - WIDTH x DEPTH read mux with tap address clamp
module ff_delay_tap_mux #(
    parameter int WIDTH  = 1,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic [DEPTH*WIDTH-1:0] i_data,
    input  logic [ADDR_W-1:0]      i_addr,
    output logic [ADDR_W-1:0]      o_eff_addr,
    output logic [WIDTH-1:0]       o_data
);
    logic [ADDR_W-1:0] w_eff;

    // Out-of-range taps read the last stage so the output is never X.
    always_comb begin
        w_eff = (int'(i_addr) > DEPTH - 1) ? ADDR_W'(DEPTH - 1) : i_addr;
    end

    always_comb begin
        o_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_eff == ADDR_W'(i)) o_data = i_data[i*WIDTH +: WIDTH];
        end
    end

    assign o_eff_addr = w_eff;
endmodule

// File: rtl/ff_delay_line.sv
// rtl/ff_delay_line.sv - addressable delay line with synchronous reset and fill tracking
module ff_delay_line
    import xilinx2asic_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 16,
    parameter int               ADDR_W  = 4,
    parameter logic [WIDTH-1:0] INIT    = {WIDTH{1'b0}},
    parameter bit               REG_OUT = 1'b0
) (
    input  logic             C,
    input  logic             R,
    ff_delay_line_if.slave   bus
);
    localparam int CNT_W = clog2(DEPTH + 1);

    if (!depth_addr_ok(DEPTH, ADDR_W)) begin : g_bad_cfg
        $error("ff_delay_line: illegal DEPTH/ADDR_W combination");
    end

    logic [WIDTH-1:0]       r_stage     [DEPTH];
    logic [WIDTH-1:0]       w_stage_nxt [DEPTH];
    logic [CNT_W-1:0]       r_fill;
    logic [CNT_W-1:0]       w_fill_nxt;
    logic [DEPTH*WIDTH-1:0] w_flat_cur;
    logic [DEPTH*WIDTH-1:0] w_flat_nxt;

    always_comb begin
        w_stage_nxt = r_stage;
        w_fill_nxt  = r_fill;
        if (bus.CE) begin
            w_stage_nxt[0] = bus.D;
            for (int i = 1; i < DEPTH; i++) w_stage_nxt[i] = r_stage[i-1];
            if (r_fill != CNT_W'(DEPTH)) w_fill_nxt = r_fill + 1'b1;
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= INIT;
            r_fill <= '0;
        end else begin
            r_stage <= w_stage_nxt;
            r_fill  <= w_fill_nxt;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign w_flat_cur[g*WIDTH +: WIDTH] = r_stage[g];
        assign w_flat_nxt[g*WIDTH +: WIDTH] = w_stage_nxt[g];
    end

    if (REG_OUT) begin : g_reg_out
        logic [WIDTH-1:0]  w_tap_nxt;
        logic [ADDR_W-1:0] w_eff_nxt;
        logic [WIDTH-1:0]  r_q;
        logic [WIDTH-1:0]  r_qlast;
        logic              r_q_valid;

        // Loads from next-state every edge, so it adds no latency beyond sampling A.
        ff_delay_tap_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mux (
            .i_data     (w_flat_nxt),
            .i_addr     (bus.A),
            .o_eff_addr (w_eff_nxt),
            .o_data     (w_tap_nxt)
        );

        always_ff @(posedge C) begin
            if (R) begin
                r_q       <= INIT;
                r_qlast   <= INIT;
                r_q_valid <= 1'b0;
            end else begin
                r_q       <= w_tap_nxt;
                r_qlast   <= w_stage_nxt[DEPTH-1];
                r_q_valid <= 32'(w_fill_nxt) > 32'(w_eff_nxt);
            end
        end

        assign bus.Q       = r_q;
        assign bus.QLAST   = r_qlast;
        assign bus.Q_VALID = r_q_valid;
    end else begin : g_comb_out
        logic [WIDTH-1:0]  w_tap;
        logic [ADDR_W-1:0] w_eff;

        ff_delay_tap_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mux (
            .i_data     (w_flat_cur),
            .i_addr     (bus.A),
            .o_eff_addr (w_eff),
            .o_data     (w_tap)
        );

        assign bus.Q       = w_tap;
        assign bus.QLAST   = r_stage[DEPTH-1];
        assign bus.Q_VALID = 32'(r_fill) > 32'(w_eff);
    end
endmodule

// File: tb/tb_ff_delay_line.sv
// tb/tb_ff_delay_line.sv - randomized self-checking bench for ff_delay_line
module tb_ff_delay_line;
    localparam logic [7:0] INIT = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce  = 1'b0;
    logic [7:0] din = 8'h00;
    logic [3:0] a   = 4'h0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ff_delay_line_if #(.WIDTH(8), .ADDR_W(4)) if0 ();
    ff_delay_line_if #(.WIDTH(8), .ADDR_W(4)) if1 ();
    ff_delay_line_if #(.WIDTH(8), .ADDR_W(4)) if2 ();

    assign if0.CE = ce;  assign if0.D = din;  assign if0.A = a;
    assign if1.CE = ce;  assign if1.D = din;  assign if1.A = a;
    assign if2.CE = ce;  assign if2.D = din;  assign if2.A = a;

    ff_delay_line #(.WIDTH(8), .DEPTH(16), .ADDR_W(4), .INIT(INIT), .REG_OUT(1'b0)) dut0 (
        .C(clk), .R(rst), .bus(if0));
    ff_delay_line #(.WIDTH(8), .DEPTH(12), .ADDR_W(4), .INIT(INIT), .REG_OUT(1'b0)) dut1 (
        .C(clk), .R(rst), .bus(if1));
    ff_delay_line #(.WIDTH(8), .DEPTH(12), .ADDR_W(4), .INIT(INIT), .REG_OUT(1'b1)) dut2 (
        .C(clk), .R(rst), .bus(if2));

    // Reference: every word shifted in since reset, newest first.
    logic [7:0] hist[$];

    logic [7:0] held_q, held_last;
    logic       held_v;
    bit         have_held = 1'b0;

    function automatic int eff(int depth, int addr);
        return (addr > depth - 1) ? depth - 1 : addr;
    endfunction

    function automatic logic [7:0] exp_q(int depth, int addr);
        int e = eff(depth, addr);
        return (hist.size() > e) ? hist[e] : INIT;
    endfunction

    function automatic logic exp_v(int depth, int addr);
        return hist.size() > eff(depth, addr);
    endfunction

    function automatic logic [7:0] exp_last(int depth);
        return (hist.size() >= depth) ? hist[depth-1] : INIT;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit r_i, input bit ce_i, input logic [7:0] d_i, input logic [3:0] a_i);
        @(negedge clk);
        rst = r_i; ce = ce_i; din = d_i; a = a_i;
        #1;
        check("d0_q_comb",  32'(if0.Q),       32'(exp_q(16, int'(a))));
        check("d0_v_comb",  32'(if0.Q_VALID), 32'(exp_v(16, int'(a))));
        check("d0_last",    32'(if0.QLAST),   32'(exp_last(16)));
        check("d1_q_comb",  32'(if1.Q),       32'(exp_q(12, int'(a))));
        check("d1_v_comb",  32'(if1.Q_VALID), 32'(exp_v(12, int'(a))));
        if (have_held) begin
            check("d2_q_hold",  32'(if2.Q),       32'(held_q));
            check("d2_v_hold",  32'(if2.Q_VALID), 32'(held_v));
            check("d2_l_hold",  32'(if2.QLAST),   32'(held_last));
        end
        @(posedge clk);
        if (r_i) hist.delete();
        else if (ce_i) begin
            hist.push_front(d_i);
            if (hist.size() > 64) void'(hist.pop_back());
        end
        #1;
        check("d0_q",    32'(if0.Q),       32'(exp_q(16, int'(a))));
        check("d0_v",    32'(if0.Q_VALID), 32'(exp_v(16, int'(a))));
        check("d0_ql",   32'(if0.QLAST),   32'(exp_last(16)));
        check("d1_q",    32'(if1.Q),       32'(exp_q(12, int'(a))));
        check("d1_v",    32'(if1.Q_VALID), 32'(exp_v(12, int'(a))));
        check("d1_ql",   32'(if1.QLAST),   32'(exp_last(12)));
        check("d2_q",    32'(if2.Q),       32'(exp_q(12, int'(a))));
        check("d2_v",    32'(if2.Q_VALID), 32'(exp_v(12, int'(a))));
        check("d2_ql",   32'(if2.QLAST),   32'(exp_last(12)));
        held_q    = exp_q(12, int'(a));
        held_v    = exp_v(12, int'(a));
        held_last = exp_last(12);
        have_held = 1'b1;
    endtask

    initial begin
        // Reset held while sweeping every tap.
        step(1, 0, 8'h00, 4'd0);
        step(1, 1, 8'h77, 4'd0);
        for (int i = 0; i < 16; i++) step(1, 0, 8'($urandom), 4'(i));
        check("rst_q_init", 32'(if0.Q), 32'(INIT));

        // Counting fill through tap 3.
        for (int k = 1; k <= 16; k++) step(0, 1, 8'(k), 4'd3);
        check("fill_qlast", 32'(if0.QLAST), 32'd1);
        check("fill_q13",   32'(if0.Q),     32'd13);

        // CE gating.
        step(0, 1, 8'h11, 4'd0);
        step(0, 0, 8'h22, 4'd0);
        step(0, 0, 8'h33, 4'd0);
        step(0, 1, 8'h44, 4'd0);
        step(0, 0, 8'h00, 4'd0);
        check("ce_stage0", 32'(if0.Q), 32'h44);
        step(0, 0, 8'h00, 4'd1);
        check("ce_stage1", 32'(if0.Q), 32'h11);

        // Reset and CE together after a full fill.
        for (int i = 0; i < 20; i++) step(0, 1, 8'($urandom), 4'($urandom_range(0, 15)));
        step(1, 1, 8'hFF, 4'd0);
        for (int i = 0; i < 16; i++) step(0, 0, 8'hFF, 4'(i));
        step(0, 1, 8'h5A, 4'd0);
        check("refill_q",  32'(if0.Q),       32'h5A);
        check("refill_v",  32'(if0.Q_VALID), 32'd1);
        step(0, 0, 8'h00, 4'd1);
        check("refill_v1", 32'(if0.Q_VALID), 32'd0);

        // Tap sweep with CE low.
        for (int i = 0; i < 14; i++) step(0, 1, 8'($urandom), 4'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 8'($urandom), 4'(i));
        step(0, 0, 8'h00, 4'd15);
        check("clamp_last", 32'(if1.Q), 32'(if1.QLAST));

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
                 8'($urandom), 4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
